// File: rtl/fp_mul_post.sv
// Post-processing stage for the single-precision multiplier: special-operand handling, exponent
// recovery, overflow/underflow substitution, sticky flags. Optional exc_cnt output via FP_MUL_POST_CNT_EN.
module fp_mul_post #(
  parameter int          BIAS = 127,
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] raw_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  exc,
  output logic [2:0]  sticky,
`ifdef FP_MUL_POST_CNT_EN
  output logic [15:0] exc_cnt,
`endif
  input  logic        sticky_clr
);

  logic adv1, adv2, hs_out;

  logic               v1_q, s1_q, inv1_q, inf1_q, zero1_q, n1_q;
  logic signed [9:0]  esum1_q;
  logic [22:0]        man1_q;
  logic               s1_d, inv1_d, inf1_d, zero1_d, n1_d;
  logic signed [9:0]  esum1_d;

  logic               v2_q;
  logic [31:0]        result_q, result_d;
  logic [2:0]         exc_q, exc_d;
  logic [2:0]         sticky_q, sticky_d, pend_q, pend_d;
  logic signed [9:0]  etrue;

  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;
  assign hs_out   = v2_q && out_ready;

  always_comb begin
    a_zero  = (op_a[30:23] == 8'h00);
    a_inf   = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'h0);
    a_nan   = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'h0);
    b_zero  = (op_b[30:23] == 8'h00);
    b_inf   = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'h0);
    b_nan   = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'h0);
    s1_d    = op_a[31] ^ op_b[31];
    inv1_d  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    inf1_d  = a_inf || b_inf;
    zero1_d = a_zero || b_zero;
    esum1_d = $signed({2'b00, op_a[30:23]}) + $signed({2'b00, op_b[30:23]}) - $signed(10'(BIAS));
    // The multiplier's exponent field differs from the plain sum only when it renormalised.
    n1_d    = (raw_prod[30:23] != esum1_d[7:0]);
  end

  always_comb begin
    etrue    = esum1_q + $signed({9'd0, n1_q});
    result_d = {s1_q, etrue[7:0], man1_q};
    exc_d    = 3'b000;
    if (inv1_q) begin
      result_d = QNAN;
      exc_d    = 3'b100;
    end else if (inf1_q) begin
      result_d = {s1_q, 8'hFF, 23'h0};
    end else if (zero1_q) begin
      result_d = {s1_q, 31'h0};
    end else if (etrue >= 10'sd255) begin
      result_d = {s1_q, 8'hFF, 23'h0};
      exc_d    = 3'b010;
    end else if (etrue <= 10'sd0) begin
      result_d = {s1_q, 31'h0};
      exc_d    = 3'b001;
    end
  end

  // A clear coinciding with a handshake wins; that handshake's flags land one cycle later.
  always_comb begin
    sticky_d = sticky_q | pend_q | (hs_out ? exc_q : 3'b000);
    pend_d   = 3'b000;
    if (sticky_clr) begin
      sticky_d = 3'b000;
      pend_d   = hs_out ? exc_q : 3'b000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      s1_q     <= 1'b0;
      inv1_q   <= 1'b0;
      inf1_q   <= 1'b0;
      zero1_q  <= 1'b0;
      n1_q     <= 1'b0;
      esum1_q  <= '0;
      man1_q   <= '0;
      v2_q     <= 1'b0;
      result_q <= '0;
      exc_q    <= '0;
      sticky_q <= '0;
      pend_q   <= '0;
    end else begin
      if (adv1) v1_q <= in_valid;
      if (adv1 && in_valid) begin
        s1_q    <= s1_d;
        inv1_q  <= inv1_d;
        inf1_q  <= inf1_d;
        zero1_q <= zero1_d;
        n1_q    <= n1_d;
        esum1_q <= esum1_d;
        man1_q  <= raw_prod[22:0];
      end
      if (adv2) v2_q <= v1_q;
      if (adv2 && v1_q) begin
        result_q <= result_d;
        exc_q    <= exc_d;
      end
      sticky_q <= sticky_d;
      pend_q   <= pend_d;
    end
  end

`ifdef FP_MUL_POST_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sticky_clr) cnt_d = 16'h0000;
    else if (hs_out && (exc_q != 3'b000) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign exc_cnt = cnt_q;
`endif

  assign out_valid = v2_q;
  assign result    = result_q;
  assign exc       = exc_q;
  assign sticky    = sticky_q;

endmodule

// File: tb/tb_fp_mul_post.sv
// Directed bench for fp_mul_post: IEEE-rule reference model with scoreboard plus literal spot checks.
module tb_fp_mul_post;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, sticky_clr;
  logic [31:0] op_a, op_b, raw_prod, result;
  logic [2:0]  exc, sticky;
`ifdef FP_MUL_POST_CNT_EN
  logic [15:0] exc_cnt;
`endif

  int errors = 0;
  int checks = 0;

  fp_mul_post dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .raw_prod(raw_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .exc(exc), .sticky(sticky),
`ifdef FP_MUL_POST_CNT_EN
    .exc_cnt(exc_cnt),
`endif
    .sticky_clr(sticky_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: returns {invalid, overflow, underflow, result} from the IEEE rules.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    int ea, eb, esum, n, et;
    bit s, az, ai, an, bz, bi, bn;
    logic [7:0] e8;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    az = (ea == 0); ai = (ea == 255) && (a[22:0] == 0); an = (ea == 255) && (a[22:0] != 0);
    bz = (eb == 0); bi = (eb == 255) && (b[22:0] == 0); bn = (eb == 255) && (b[22:0] != 0);
    esum = ea + eb - 127;
    n    = (int'(p[30:23]) != (esum & 255)) ? 1 : 0;
    et   = esum + n;
    e8   = 8'(et);
    if (an || bn || (ai && bz) || (bi && az)) return {3'b100, 32'h7FC00000};
    if (ai || bi) return {3'b000, s, 8'hFF, 23'h0};
    if (az || bz) return {3'b000, s, 31'h0};
    if (et >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (et <= 0)   return {3'b001, s, 31'h0};
    return {3'b000, s, e8, p[22:0]};
  endfunction

  logic [34:0] q[$];
  logic [2:0]  sticky_m = 3'b000, pend_m = 3'b000, hs_exc;
  logic        hold_v = 1'b0;
  logic [34:0] hold_val, e;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      sticky_m = 3'b000;
      pend_m   = 3'b000;
      hold_v   = 1'b0;
    end else begin
      chk("sticky_model", {32'h0, sticky}, {32'h0, sticky_m});
      if (hold_v) begin
        chk("hold_valid", {34'h0, out_valid}, 35'h1);
        chk("hold_data", {exc, result}, hold_val);
      end
      hs_exc = 3'b000;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got result=%h with no pending input", result);
        end else begin
          e = q.pop_front();
          chk("sb_out", {exc, result}, e);
          hs_exc = e[34:32];
        end
      end
      if (sticky_clr) begin
        sticky_m = 3'b000;
        pend_m   = hs_exc;
      end else begin
        sticky_m = sticky_m | pend_m | hs_exc;
        pend_m   = 3'b000;
      end
      if (in_valid && in_ready) q.push_back(model(op_a, op_b, raw_prod));
      hold_v   = out_valid && !out_ready;
      hold_val = {exc, result};
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    bit ok = 0;
    op_a = a; op_b = b; raw_prod = p; in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      sync();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 for 20 cycles, expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_lat(input string name, input logic [31:0] r, input logic [2:0] x);
    @(negedge clk);
    chk({name, "_lat1"}, {34'h0, out_valid}, 35'h0);
    @(negedge clk);
    chk({name, "_lat2"}, {34'h0, out_valid}, 35'h1);
    chk(name, {exc, result}, {x, r});
    sync();
  endtask

  typedef struct { logic [31:0] a, b, p; } vec_t;
  vec_t vt[9];
  vec_t bp[4];

  initial begin
    int idx, acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
    op_a = '0; op_b = '0; raw_prod = '0;
    #12;
    chk("rst_in_ready", {34'h0, in_ready}, 35'h1);
    chk("rst_out_valid", {34'h0, out_valid}, 35'h0);
    chk("rst_out", {exc, result}, 35'h0);
    chk("rst_sticky", {32'h0, sticky}, 35'h0);
    sync(); rst = 1'b0;

    chk("model_2x3", model(32'h40000000, 32'h40400000, 32'h40C00000), {3'b000, 32'h40C00000});
    chk("model_1p5sq", model(32'h3FC00000, 32'h3FC00000, 32'h40100000), {3'b000, 32'h40100000});
    chk("model_ovf", model(32'h7F000000, 32'h7F000000, 32'h3E800000), {3'b010, 32'h7F800000});
    chk("model_inf0", model(32'h7F800000, 32'h80000000, 32'h0), {3'b100, 32'h7FC00000});

    sync();
    send(32'h40000000, 32'h40400000, 32'h40C00000);
    expect_lat("mul_2x3", 32'h40C00000, 3'b000);

    send(32'h7F000000, 32'h7F000000, 32'h3E800000);
    expect_lat("overflow", 32'h7F800000, 3'b010);
    @(negedge clk);
    chk("ovf_sticky", {32'h0, sticky}, {32'h0, 3'b010});
    sync();

    send(32'h10000000, 32'h10000000, 32'h00000000);
    expect_lat("underflow", 32'h00000000, 3'b001);
    sticky_clr = 1'b1; sync(); sticky_clr = 1'b0;
    @(negedge clk);
    chk("clr_sticky", {32'h0, sticky}, 35'h0);
    sync();

    send(32'h7F800000, 32'h80000000, 32'h7F800000);
    expect_lat("inf_x_zero", 32'h7FC00000, 3'b100);
    // -inf * 2.0 keeps the operand sign: negative infinity.
    send(32'hFF800000, 32'h40000000, 32'hFF800000);
    expect_lat("neginf_x2", 32'hFF800000, 3'b000);

    send(32'h10000000, 32'h10000000, 32'h00000000);
    sync();
    sticky_clr = 1'b1; sync(); sticky_clr = 1'b0;
    @(negedge clk);
    chk("clr_wins", {32'h0, sticky}, 35'h0);
    sync();
    @(negedge clk);
    chk("clr_defer", {32'h0, sticky}, {32'h0, 3'b001});
    sync();

    vt[0] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000};
    vt[1] = '{32'hC0000000, 32'h40400000, 32'hC0C00000};
    vt[2] = '{32'h00000000, 32'h40000000, 32'h00000000};
    vt[3] = '{32'h00000001, 32'h3F800000, 32'h00000000};
    vt[4] = '{32'h80000000, 32'h7F800000, 32'h7FC00000};
    vt[5] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00001};
    vt[6] = '{32'h7F400000, 32'h3FC00000, 32'h7F800000};
    vt[7] = '{32'h00800000, 32'h3F800000, 32'h00800000};
    vt[8] = '{32'h00800000, 32'h3F000000, 32'h00000000};
    for (int i = 0; i < 9; i++) begin
      op_a = vt[i].a; op_b = vt[i].b; raw_prod = vt[i].p; in_valid = 1'b1;
      @(negedge clk);
      chk("stream_ready", {34'h0, in_ready}, 35'h1);
      sync();
    end
    in_valid = 1'b0;
    repeat (4) sync();

    bp[0] = '{32'h40000000, 32'h40000000, 32'h40800000};
    bp[1] = '{32'h3F800000, 32'h40400000, 32'h40400000};
    bp[2] = '{32'h40400000, 32'h40400000, 32'h41100000};
    bp[3] = '{32'hBF800000, 32'h3F800000, 32'hBF800000};
    out_ready = 1'b0;
    idx = 0; acc = 0;
    for (int c = 0; c < 4; c++) begin
      op_a = bp[idx].a; op_b = bp[idx].b; raw_prod = bp[idx].p; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin acc++; idx++; end
      sync();
    end
    chk("bp_accepted", 35'(acc), 35'd2);
    @(negedge clk);
    chk("bp_in_ready", {34'h0, in_ready}, 35'h0);
    sync();
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      op_a = bp[idx].a; op_b = bp[idx].b; raw_prod = bp[idx].p; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) idx++;
      sync();
    end
    in_valid = 1'b0;
    chk("bp_all_sent", 35'(idx), 35'd4);
    repeat (4) sync();
    chk("bp_drained", 35'(q.size()), 35'd0);

    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_a = bp[i].a; op_b = bp[i].b; raw_prod = bp[i].p; in_valid = 1'b1;
      sync();
    end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk("rst_async", {34'h0, out_valid}, 35'h0);
    sync(); sync();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_rel_in_ready", {34'h0, in_ready}, 35'h1);
    chk("rst_rel_sticky", {32'h0, sticky}, 35'h0);
    for (int i = 0; i < 5; i++) begin
      chk("no_stale", {34'h0, out_valid}, 35'h0);
      @(negedge clk);
    end
    sync();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
